// File: rtl/psram_spi_responder.sv
// psram_spi_responder: SPI (mode 0) PSRAM target backed by a byte-wide array.
// cs_n/sclk/mosi are oversampled on clk; clk must run at least 8x sclk.
// Commands: 0x03 read, 0x0B fast read (dummy cycles), 0x02 write,
// 0x66/0x99 accepted and ignored; anything else flags cmd_error.
// Optional macro PSRAM_PAGE_WRAP_EN: address increment wraps inside a
// 2^PAGE_AW page instead of across the whole 2^MEM_AW array.
module psram_spi_responder #(
  parameter int unsigned ADDR_WIDTH   = 24,
  parameter int unsigned MEM_AW       = 12,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned PAGE_AW      = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        busy,
  output logic [7:0]  last_cmd,
  output logic        cmd_error,
  output logic [15:0] wr_byte_count
);

  localparam int unsigned CNT_W = 8;
`ifdef PSRAM_PAGE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  localparam int unsigned WRAP_AW = WRAP_EN ? PAGE_AW : MEM_AW;
  localparam logic [MEM_AW-1:0] WRAP_MASK = MEM_AW'((64'(1) << WRAP_AW) - 64'(1));

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_FAST  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RSTEN = 8'h66;
  localparam logic [7:0] CMD_RST   = 8'h99;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE} state_t;

  // synchronizer chains and edge detection history
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic cs_s, sclk_s, mosi_s, cs_prev, sclk_prev;
  logic sclk_rise, sclk_fall, cs_fall;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d, addr_next, mem_raddr;
  logic [6:0]        shreg_q, shreg_d;
  logic [7:0]        shreg_in;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        pf_q, pf_d;
  logic              miso_q, miso_d, oe_q, oe_d, shift_ok_q, shift_ok_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic [7:0]        last_cmd_q, last_cmd_d;
  logic              cmd_error_q, cmd_error_d;
  logic              rd_start_q, rd_start_d, ld_q, ld_d;
  logic              pf_req_q, pf_req_d, pf_cap_q, pf_cap_d;
  logic              mem_we;
  logic [7:0]        mem_rdata;
  logic [7:0]        mem [0:(1 << MEM_AW)-1];

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = cs_prev & ~cs_s;

  assign shreg_in  = {shreg_q, mosi_s};
  assign addr_next = ((addr_q + MEM_AW'(1)) & WRAP_MASK) | (addr_q & ~WRAP_MASK);
  assign mem_raddr = rd_start_q ? addr_q : addr_next;

  // input synchronizers, edge history and busy flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
      busy      <= ~cs_s;
    end
  end

  // byte array: one write port (commit), one registered read port
  always_ff @(posedge clk) begin
    if (mem_we && resetn) mem[addr_q] <= shreg_in;
    mem_rdata <= mem[mem_raddr];
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      shreg_q     <= '0;
      cmd_q       <= '0;
      tx_q        <= '0;
      pf_q        <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      shift_ok_q  <= 1'b0;
      wr_cnt_q    <= '0;
      last_cmd_q  <= '0;
      cmd_error_q <= 1'b0;
      rd_start_q  <= 1'b0;
      ld_q        <= 1'b0;
      pf_req_q    <= 1'b0;
      pf_cap_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_q      <= addr_d;
      shreg_q     <= shreg_d;
      cmd_q       <= cmd_d;
      tx_q        <= tx_d;
      pf_q        <= pf_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      shift_ok_q  <= shift_ok_d;
      wr_cnt_q    <= wr_cnt_d;
      last_cmd_q  <= last_cmd_d;
      cmd_error_q <= cmd_error_d;
      rd_start_q  <= rd_start_d;
      ld_q        <= ld_d;
      pf_req_q    <= pf_req_d;
      pf_cap_q    <= pf_cap_d;
    end
  end

  // next-state and datapath logic; cs_n high overrides everything but a commit
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    addr_d      = addr_q;
    shreg_d     = shreg_q;
    cmd_d       = cmd_q;
    tx_d        = tx_q;
    pf_d        = pf_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    shift_ok_d  = shift_ok_q;
    wr_cnt_d    = wr_cnt_q;
    last_cmd_d  = last_cmd_q;
    cmd_error_d = 1'b0;
    rd_start_d  = 1'b0;
    ld_d        = rd_start_q;
    pf_req_d    = 1'b0;
    pf_cap_d    = pf_req_q;
    mem_we      = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        oe_d      = 1'b0;
        miso_d    = 1'b0;
        if (cs_fall) state_d = CMD;
      end
      CMD: begin
        if (sclk_rise) begin
          shreg_d   = shreg_in[6:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            bit_cnt_d  = '0;
            last_cmd_d = shreg_in;
            cmd_d      = shreg_in;
            case (shreg_in)
              CMD_READ, CMD_FAST, CMD_WRITE: state_d = ADDR;
              CMD_RSTEN, CMD_RST:            state_d = IGNORE;
              default: begin
                cmd_error_d = 1'b1;
                state_d     = IGNORE;
              end
            endcase
          end
        end
      end
      ADDR: begin
        if (sclk_rise) begin
          addr_d    = {addr_q[MEM_AW-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
            bit_cnt_d = '0;
            if (cmd_q == CMD_WRITE) begin
              state_d = WRITE;
            end else if (cmd_q == CMD_FAST && DUMMY_CYCLES != 0) begin
              state_d = DUMMY;
            end else begin
              state_d    = READ;
              rd_start_d = 1'b1;
              shift_ok_d = 1'b0;
            end
          end
        end
      end
      DUMMY: begin
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
            bit_cnt_d  = '0;
            state_d    = READ;
            rd_start_d = 1'b1;
            shift_ok_d = 1'b0;
          end
        end
      end
      READ: begin
        // first byte arrives one clk after the read is issued
        if (ld_q) begin
          tx_d     = {mem_rdata[6:0], 1'b0};
          miso_d   = mem_rdata[7];
          oe_d     = 1'b1;
          pf_req_d = 1'b1;
        end
        if (pf_cap_q) pf_d = mem_rdata;
        // the fall right after entry keeps bit7; later falls advance
        if (sclk_fall && shift_ok_q) begin
          miso_d     = tx_q[7];
          tx_d       = {tx_q[6:0], 1'b0};
          shift_ok_d = 1'b0;
        end
        if (sclk_rise) begin
          shift_ok_d = 1'b1;
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            bit_cnt_d = '0;
            addr_d    = addr_next;
            tx_d      = pf_q;
            pf_req_d  = 1'b1;
          end
        end
      end
      WRITE: begin
        if (sclk_rise) begin
          shreg_d   = shreg_in[6:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            bit_cnt_d = '0;
            mem_we    = 1'b1;
            addr_d    = addr_next;
            if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
          end
        end
      end
      IGNORE: begin
        bit_cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q != IDLE && cs_s) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      oe_d       = 1'b0;
      miso_d     = 1'b0;
      shift_ok_d = 1'b0;
      rd_start_d = 1'b0;
      ld_d       = 1'b0;
      pf_req_d   = 1'b0;
      pf_cap_d   = 1'b0;
    end
  end

  assign spi_miso      = miso_q;
  assign spi_miso_oe   = oe_q;
  assign last_cmd      = last_cmd_q;
  assign cmd_error     = cmd_error_q;
  assign wr_byte_count = wr_cnt_q;

endmodule

// File: tb/tb_psram_spi_responder.sv
// Testbench for psram_spi_responder: SPI initiator tasks plus a byte-array
// reference model with per-byte valid flags.
module tb_psram_spi_responder;

  localparam int HALF = 8;  // clk cycles per sclk half period

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        busy;
  logic [7:0]  last_cmd;
  logic        cmd_error;
  logic [15:0] wr_byte_count;

  always #5 clk = ~clk;

  psram_spi_responder dut (
    .clk(clk), .resetn(resetn),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .busy(busy),
    .last_cmd(last_cmd), .cmd_error(cmd_error), .wr_byte_count(wr_byte_count)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] mdl [4096];
  bit         vld [4096];
  int         exp_cnt = 0;
  logic [7:0] wq [$];
  logic [23:0] starts [$];
  int          lens [$];
  logic        last_oe;
  logic        oe_bit7;
  int          err_pulses = 0;
  int          oe_hi = 0;

  // event counters for the pulse / output-enable observations
  always @(negedge clk) begin
    if (cmd_error === 1'b1) err_pulses++;
    if (spi_miso_oe === 1'b1) oe_hi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic int nxt(input int a);
`ifdef PSRAM_PAGE_WRAP_EN
    return (a / 1024) * 1024 + ((a % 1024) + 1) % 1024;
`else
    return (a + 1) % 4096;
`endif
  endfunction

  task automatic xfer_bit(input logic b, output logic r);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    r = spi_miso;
    last_oe = spi_miso_oe;
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] b, output logic [7:0] r);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(b[i], rb);
      r[i] = rb;
      if (i == 7) oe_bit7 = last_oe;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a24);
    logic [7:0] d;
    logic [7:0] ab;
    xfer_byte(cmd, d);
    for (int k = 2; k >= 0; k--) begin
      ab = 8'((int'(a24) >> (8 * k)) % 256);
      xfer_byte(ab, d);
    end
  endtask

  // write the bytes in wq starting at a24 and update the model
  task automatic do_write(input logic [23:0] a24);
    logic [7:0] d;
    int a;
    a = int'(a24) % 4096;
    cs_low();
    send_hdr(8'h02, a24);
    foreach (wq[i]) begin
      xfer_byte(wq[i], d);
      mdl[a] = wq[i];
      vld[a] = 1'b1;
      a = nxt(a);
      if (exp_cnt < 65535) exp_cnt++;
    end
    cs_high();
    check("wr_count", 32'(wr_byte_count), 32'(exp_cnt));
    check("wr_last_cmd", 32'(last_cmd), 32'h02);
  endtask

  // read n bytes with cmd (0x03 / 0x0B) and compare known bytes to the model
  task automatic do_read(input logic [7:0] cmd, input logic [23:0] a24, input int n, input string tag);
    logic [7:0] d;
    logic rb;
    int a;
    a = int'(a24) % 4096;
    cs_low();
    check({tag, "_busy"}, 32'(busy), 32'h1);
    send_hdr(cmd, a24);
    if (cmd == 8'h0B) begin
      for (int i = 0; i < 8; i++) begin
        xfer_bit(1'($urandom_range(0, 1)), rb);
        check({tag, "_dummy_oe"}, 32'(last_oe), 32'h0);
      end
    end
    for (int k = 0; k < n; k++) begin
      xfer_byte(8'($urandom_range(0, 255)), d);
      if (k == 0) check({tag, "_first_oe"}, 32'(oe_bit7), 32'h1);
      if (vld[a]) check($sformatf("%s_data@%03h", tag, a), 32'(d), 32'(mdl[a]));
      a = nxt(a);
    end
    cs_high();
    check({tag, "_last_cmd"}, 32'(last_cmd), 32'(cmd));
    check({tag, "_oe_idle"}, 32'(spi_miso_oe), 32'h0);
  endtask

  initial begin
    logic [7:0]  d;
    logic        rb;
    logic [23:0] a24;
    int          p0, o0, len;

    // reset values
    repeat (4) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 32'h0);
    check("rst_oe", 32'(spi_miso_oe), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_last_cmd", 32'(last_cmd), 32'h0);
    check("rst_cmd_error", 32'(cmd_error), 32'h0);
    check("rst_wr_count", 32'(wr_byte_count), 32'h0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // write then read
    wq = '{8'hA5, 8'h3C};
    do_write(24'h000010);
    do_read(8'h03, 24'h000010, 2, "rd");

    // fast read with dummy cycles
    do_read(8'h0B, 24'h000010, 2, "fast");

    // upper received address bits are ignored
    do_read(8'h03, 24'hABC010, 1, "hi_addr");

    // unsupported command: one error pulse, no drive, no writes
    p0 = err_pulses;
    o0 = oe_hi;
    cs_low();
    xfer_byte(8'h5A, d);
    for (int i = 0; i < 32; i++) xfer_bit(1'($urandom_range(0, 1)), rb);
    cs_high();
    check("unsup_pulses", 32'(err_pulses - p0), 32'h1);
    check("unsup_oe", 32'(oe_hi - o0), 32'h0);
    check("unsup_count", 32'(wr_byte_count), 32'(exp_cnt));
    check("unsup_last_cmd", 32'(last_cmd), 32'h5A);
    do_read(8'h03, 24'h000010, 1, "post_unsup");

    // accepted no-op command
    p0 = err_pulses;
    cs_low();
    xfer_byte(8'h66, d);
    for (int i = 0; i < 8; i++) xfer_bit(1'($urandom_range(0, 1)), rb);
    cs_high();
    check("rsten_pulses", 32'(err_pulses - p0), 32'h0);
    check("rsten_last_cmd", 32'(last_cmd), 32'h66);
    check("rsten_count", 32'(wr_byte_count), 32'(exp_cnt));

    // partial byte discarded at cs_n rise
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(8'($urandom_range(0, 255)));
    do_write(24'h000020);
    cs_low();
    send_hdr(8'h02, 24'h000020);
    xfer_byte(8'hFF, d);
    mdl[32] = 8'hFF;
    exp_cnt++;
    for (int i = 0; i < 4; i++) xfer_bit(1'b0, rb);
    cs_high();
    check("partial_count", 32'(wr_byte_count), 32'(exp_cnt));
    do_read(8'h03, 24'h000020, 3, "partial");

    // address wrap: distinct markers where a wrapped byte could land
    wq = '{8'h5E};
    do_write(24'h000000);
    wq = '{8'h6F};
    do_write(24'h000400);
    wq = '{8'h11, 8'h22};
    do_write(24'h0003FF);
    do_read(8'h03, 24'h000000, 1, "wrap_lo");
    do_read(8'h03, 24'h000400, 1, "wrap_hi");
    do_read(8'h03, 24'h0003FF, 2, "wrap_rd");
    wq = '{8'h77, 8'h88};
    do_write(24'h000FFF);
    do_read(8'h0B, 24'h000FFF, 2, "wrap_top");

    // randomized writes followed by reads of the same regions
    for (int t = 0; t < 5; t++) begin
      a24 = 24'($urandom);
      len = int'($urandom_range(1, 4));
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back(8'($urandom_range(0, 255)));
      do_write(a24);
      starts.push_back(a24);
      lens.push_back(len);
    end
    foreach (starts[i]) begin
      do_read(($urandom_range(0, 1) == 1) ? 8'h0B : 8'h03, starts[i], lens[i] + 1, $sformatf("rnd%0d", i));
    end

    // reset in the middle of a read data phase
    cs_low();
    send_hdr(8'h03, 24'h000010);
    for (int i = 0; i < 3; i++) xfer_bit(1'b0, rb);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_oe", 32'(spi_miso_oe), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_miso", 32'(spi_miso), 32'h0);
    check("midrst_count", 32'(wr_byte_count), 32'h0);
    check("midrst_last_cmd", 32'(last_cmd), 32'h0);
    resetn = 1'b1;
    exp_cnt = 0;
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (3 * HALF) @(negedge clk);
    check("postrst_count", 32'(wr_byte_count), 32'h0);
    do_read(8'h03, 24'h000010, 2, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psram_spi_responder.md
Name: psram_spi_responder

Overview:
Synthesizable SPI PSRAM target. It is the chip-side counterpart that answers the PSRAM controller's command/address/data sequences. A byte-wide internal memory array backs it. It is used as the loopback target in FPGA bring-up and as the DUT-side model in controller benches. It oversamples cs_n/sclk/mosi on the system clock and drives miso from internal state.

Parameters:
ADDR_WIDTH, 24, address bits received after the command byte (MSB first)
MEM_AW, 12, log2 of internal array depth in bytes; received address is used modulo 2^MEM_AW
DUMMY_CYCLES, 8, sclk cycles between the address and first data bit for fast read (0x0B)
SYNC_STAGES, 2, synchronizer flops on cs_n, sclk and mosi
PAGE_AW, 10, log2 of page size; used only when PSRAM_PAGE_WRAP_EN is defined

Ports:
clk  in  1  system clock; must be at least 8x the sclk frequency
resetn  in  1  reset: synchronous, active-low
spi_cs_n  in  1  chip select, active-low, asynchronous to clk
spi_sclk  in  1  SPI clock, mode 0, asynchronous to clk
spi_mosi  in  1  serial data from the initiator
spi_miso  out  1  serial data to the initiator
spi_miso_oe  out  1  output enable for the miso pad
busy  out  1  high while cs_n (synchronized) is low
last_cmd  out  8  last complete command byte received
cmd_error  out  1  one-clk pulse when an unsupported command byte completes
wr_byte_count  out  16  saturating count of bytes committed to the array

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, busy=0, last_cmd=0, cmd_error=0, wr_byte_count=0, state=IDLE. Array contents are not reset.
- Synchronization and edge detection:
  - cs_n, sclk and mosi pass through SYNC_STAGES flops.
  - A rise is a synchronized sclk 0->1; a fall is 1->0.
  - mosi is sampled on a rise. miso changes only on a fall, or on the initial load described under READ.
- Bit order: MSB first for command, address and data.
- States: IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE.
- IDLE:
  - cs_n falls -> CMD; bit_cnt=0.
  - Edges are ignored while cs_n is high.
- CMD: after 8 rises, last_cmd is updated.
  - 0x03 or 0x0B -> ADDR.
  - 0x02 -> ADDR.
  - 0x66 or 0x99 -> IGNORE. No effect on array or counters; they are accepted, not errors.
  - Any other value: cmd_error pulses 1 clk -> IGNORE.
- ADDR:
  - Shift ADDR_WIDTH bits into addr.
  - After the last rise: 0x0B -> DUMMY; 0x03 -> READ; 0x02 -> WRITE.
- DUMMY: count DUMMY_CYCLES rises -> READ. miso_oe stays 0.
- READ:
  - On entry, issue an array read at addr. Within 4 clks the data is loaded into tx_shift, miso_oe=1 and spi_miso=bit7. This happens before the next fall, so the bit is valid for the initiator's next rise.
  - Each fall shifts out the next bit.
  - After the 8th data rise, addr increments and the next byte is loaded. A prefetch register holds mem[addr+1] so the next byte is ready at that rise.
  - Reads are unbounded until cs_n rises.
- WRITE:
  - Shift 8 mosi bits, then commit the byte to mem[addr], increment addr and increment wr_byte_count (saturating at 0xFFFF).
  - A partial byte (fewer than 8 bits) at cs_n rise is discarded.
- Address increment (default): addr wraps modulo 2^MEM_AW (0xFFF -> 0x000). Upper received bits are ignored.
- cs_n rises in any state -> IDLE within SYNC_STAGES+1 clks:
  - miso_oe=0, spi_miso=0, bit_cnt=0.
  - A write commit already issued completes; nothing else.
- Simultaneous events:
  - cs_n rise coinciding with the 8th write rise: the byte commits (sampled first, then abort).
  - cs_n fall while still in IDLE with a stale rise: the rise is ignored.
- Reset mid-transaction: every state and output returns to reset values on the next clk. The array keeps its data.
- busy mirrors synchronized ~cs_n.

Optional Feature:
PSRAM_PAGE_WRAP_EN:
- Defined: read/write address increment wraps within a 2^PAGE_AW page. addr[PAGE_AW-1:0] increments; the upper bits are held. 0x3FF -> 0x000, 0x7FF -> 0x400.
- Undefined: linear wrap modulo 2^MEM_AW only. PAGE_AW is unused.

Test Plan:
- Write then read:
  - Stimulus: cs low; 0x02, addr 0x000010, data 0xA5 0x3C; cs high. Then 0x03, addr 0x000010, 16 clocks.
  - Response: miso returns 0xA5 0x3C; wr_byte_count=2; last_cmd=0x03.
- Fast read:
  - Stimulus: 0x0B, addr 0x000010, 8 dummy clocks, 16 clocks.
  - Response: 0xA5 0x3C; miso_oe=0 through the dummy cycles and 1 from the first data bit.
- Unsupported command:
  - Stimulus: command 0x5A followed by 32 clocks.
  - Response: exactly one cmd_error pulse; miso_oe stays 0; wr_byte_count unchanged; a subsequent read of 0x10 still returns 0xA5.
- Partial byte abort:
  - Stimulus: 0x02, addr 0x20, 0xFF fully, then 4 bits of 0x00, then cs high.
  - Response: mem[0x20]=0xFF, mem[0x21] unchanged; count +1 only.
- Wrap:
  - Stimulus: 0x02, addr 0x0003FF, data 0x11 0x22.
  - Response without the macro: 0x22 lands at 0x400.
  - Response with PSRAM_PAGE_WRAP_EN: 0x22 lands at 0x000.
- Reset mid-read:
  - Stimulus: resetn low for 1 clk during the READ data phase.
  - Response: next clk miso_oe=0, busy=0, state IDLE; a following 0x03 transaction reads correct data.
